// File: rtl/i2s_mic_rx_if.sv
// Microphone-side I2S pins and the 16-bit sample stream of i2s_mic_rx.
// master = receiver (drives SCK/WS and the sample outputs), slave = mic model / consumer.
interface i2s_mic_rx_if;
  logic        mic_sck;
  logic        mic_ws;
  logic        mic_sd;
  logic [15:0] data;
  logic        data_we;
  logic        ready;

  modport master (output mic_sck, mic_ws, data, data_we, ready, input mic_sd);
  modport slave  (input mic_sck, mic_ws, data, data_we, ready, output mic_sd);
endinterface

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a 24-bit MEMS mic: one scaled, saturated 16-bit sample per frame.
// Optional DC blocker after scaling when I2S_MIC_DC_REMOVE_EN is defined.
module i2s_mic_rx #(
  parameter int SCK_HALF       = 4,
  parameter int CHANNEL        = 0,
  parameter int GAIN           = 0,
  parameter int STARTUP_FRAMES = 4096,
  parameter int is_simulation  = 0
) (
  input  logic        clk,
  input  logic        reset_p,
  i2s_mic_rx_if.master bus
);
  localparam int STARTUP = (is_simulation != 0) ? 2 : STARTUP_FRAMES;
  localparam int DW      = $clog2(SCK_HALF);
  localparam int FW      = $clog2(STARTUP + 1);
  localparam int SHIFT   = 8 - GAIN;

  logic [DW-1:0] r_div_cnt;
  logic          r_sck;
  logic [5:0]    r_bit_cnt;
  logic [23:0]   r_shift;
  logic          r_proc;
  logic [FW-1:0] r_frame_cnt;
  logic          r_ready;
  logic [15:0]   r_data;
  logic          r_we;

  logic              w_div_wrap, w_fall, w_cap;
  logic [4:0]        w_slot;
  logic signed [23:0] w_scaled;
  logic [15:0]       w_x, w_out;

  function automatic logic [15:0] sat16(input logic signed [24:0] v);
    if (v > 25'sd32767)       return 16'h7FFF;
    else if (v < -25'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  assign w_div_wrap = (r_div_cnt == DW'(SCK_HALF - 1));
  // last clk of the SCK high phase: sample SD here, and SCK falls on this edge
  assign w_fall     = w_div_wrap & r_sck;
  assign w_slot     = r_bit_cnt[4:0];
  assign w_cap      = w_fall && (r_bit_cnt[5] == CHANNEL[0]) &&
                      (w_slot >= 5'd1) && (w_slot <= 5'd24);
  assign w_scaled   = $signed(r_shift) >>> SHIFT;
  assign w_x        = sat16({w_scaled[23], w_scaled});

`ifdef I2S_MIC_DC_REMOVE_EN
  logic signed [23:0] r_acc;
  logic signed [16:0] w_diff;

  // y = x - acc/256; acc integrates the saturated output
  assign w_diff = $signed({w_x[15], w_x}) - $signed({r_acc[23], r_acc[23:8]});
  assign w_out  = sat16({{8{w_diff[16]}}, w_diff});

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)     r_acc <= '0;
    else if (r_proc) r_acc <= r_acc + $signed({{8{w_out[15]}}, w_out});
  end
`else
  assign w_out = w_x;
`endif

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_div_cnt   <= '0;
      r_sck       <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_proc      <= 1'b0;
      r_frame_cnt <= '0;
      r_ready     <= 1'b0;
      r_data      <= '0;
      r_we        <= 1'b0;
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DW'(1);
      if (w_div_wrap) r_sck <= ~r_sck;
      if (w_fall)     r_bit_cnt <= r_bit_cnt + 6'd1;
      if (w_cap)      r_shift <= {r_shift[22:0], bus.mic_sd};
      r_proc <= w_cap && (w_slot == 5'd24);
      if (w_fall && (r_bit_cnt == 6'd63) && !r_ready) begin
        if (r_frame_cnt == FW'(STARTUP - 1)) r_ready <= 1'b1;
        else                                 r_frame_cnt <= r_frame_cnt + FW'(1);
      end
      // data tracks every processed sample; the strobe only once settled
      r_we <= 1'b0;
      if (r_proc) begin
        r_data <= w_out;
        r_we   <= r_ready;
      end
    end
  end

  assign bus.mic_sck = r_sck;
  assign bus.mic_ws  = r_bit_cnt[5];
  assign bus.data    = r_data;
  assign bus.data_we = r_we;
  assign bus.ready   = r_ready;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Scoreboard bench: three receivers (GAIN0/CH0, GAIN8/CH0, GAIN0/CH1) share one mic model.
module tb_i2s_mic_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  i2s_mic_rx_if if0 ();
  i2s_mic_rx_if if8 ();
  i2s_mic_rx_if if1 ();

  i2s_mic_rx #(.SCK_HALF(4), .CHANNEL(0), .GAIN(0), .STARTUP_FRAMES(4096), .is_simulation(1))
    u0 (.clk(clk), .reset_p(rst), .bus(if0));
  i2s_mic_rx #(.SCK_HALF(4), .CHANNEL(0), .GAIN(8), .STARTUP_FRAMES(4096), .is_simulation(1))
    u8 (.clk(clk), .reset_p(rst), .bus(if8));
  i2s_mic_rx #(.SCK_HALF(4), .CHANNEL(1), .GAIN(0), .STARTUP_FRAMES(4096), .is_simulation(1))
    u1 (.clk(clk), .reset_p(rst), .bus(if1));

  // ---------------- mic model: changes SD after each SCK falling edge
  logic        sd = 1'bx;
  logic [5:0]  mcnt = '0;
  logic [23:0] cur_l = '0, cur_r = '0;
  event        frame_start;
  wire  [5:0]  mnext = mcnt + 6'd1;
  wire  [23:0] mword = mnext[5] ? cur_r : cur_l;
  wire  [4:0]  mbit  = 5'd24 - mnext[4:0];

  assign if0.mic_sd = sd;
  assign if8.mic_sd = sd;
  assign if1.mic_sd = sd;

  always @(negedge if0.mic_sck or posedge rst) begin
    if (rst) begin
      mcnt <= '0;
      sd   <= 1'bx;
    end else begin
      mcnt <= mnext;
      if (mnext[4:0] >= 5'd1 && mnext[4:0] <= 5'd24) sd <= mword[mbit];
      else                                           sd <= 1'bx;
      if (mnext == 6'd0) -> frame_start;
    end
  end

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- directed vectors (expected values computed by hand)
  typedef struct {
    logic [23:0] l, r;
    logic [15:0] e0, e8, e1;
  } vec_t;
  vec_t vt[8];

  logic [15:0] q0[$], q8[$], q1[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic load(input int i);
`ifdef I2S_MIC_DC_REMOVE_EN
    cur_l = 24'h100000;
    cur_r = vt[i].r;
`else
    cur_l = vt[i].l;
    cur_r = vt[i].r;
    q0.push_back(vt[i].e0);
    q8.push_back(vt[i].e8);
    q1.push_back(vt[i].e1);
`endif
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sck"},   if0.mic_sck, 0);
    chk({tag, "_ws"},    if0.mic_ws,  0);
    chk({tag, "_data"},  if0.data,    0);
    chk({tag, "_we"},    if0.data_we, 0);
    chk({tag, "_ready"}, if0.ready,   0);
  endtask

  task automatic ready_timing(input string tag);
    repeat (1023) @(posedge clk);
    #1 chk({tag, "_ready_low_at_1023"}, if0.ready, 0);
    @(posedge clk);
    #1 chk({tag, "_ready_at_1024"}, if0.ready, 1);
  endtask

  // ---------------- monitors
  int last0 = -1;
  int dc_prev = -1;
  always @(negedge clk) begin
    if (rst) begin
      last0   = -1;
      dc_prev = -1;
    end else if (if0.data_we) begin
      chk("u0_we_after_startup", cyc >= 1024, 1);
      if (last0 >= 0) chk("u0_we_spacing", cyc - last0, 512);
      last0 = cyc;
`ifdef I2S_MIC_DC_REMOVE_EN
      if (dc_prev < 0) chk("dc_first", if0.data, 16'h1000);
      else chk("dc_decay", ($signed(if0.data) < dc_prev) && ($signed(if0.data) >= 0), 1);
      dc_prev = int'($signed(if0.data));
`else
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_we: got data %h expected no strobe", if0.data);
      end else chk("u0_data", if0.data, q0.pop_front());
`endif
    end
  end

`ifndef I2S_MIC_DC_REMOVE_EN
  always @(negedge clk) begin
    if (!rst && if8.data_we) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL u8_unexpected_we: got data %h expected no strobe", if8.data);
      end else chk("u8_data", if8.data, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && if1.data_we) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_unexpected_we: got data %h expected no strobe", if1.data);
      end else chk("u1_data", if1.data, q1.pop_front());
    end
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus
  initial begin
    vt[0] = '{24'h123456, 24'h00FF00, 16'h1234, 16'h7FFF, 16'h00FF};
    vt[1] = '{24'h7FFFFF, 24'h800000, 16'h7FFF, 16'h7FFF, 16'h8000};
    vt[2] = '{24'h800000, 24'hFFFF00, 16'h8000, 16'h8000, 16'hFFFF};
    vt[3] = '{24'hFFFF00, 24'hAAAAAA, 16'hFFFF, 16'hFF00, 16'hAAAA};
    vt[4] = '{24'hAAAAAA, 24'h00FF00, 16'hAAAA, 16'h8000, 16'h00FF};
    vt[5] = '{24'h000080, 24'h123456, 16'h0000, 16'h0080, 16'h1234};
    vt[6] = '{24'hFF8000, 24'h000100, 16'hFF80, 16'h8000, 16'h0001};
    vt[7] = '{24'h007FFF, 24'hFFFFFF, 16'h007F, 16'h7FFF, 16'hFFFF};

    rst = 1'b1;
    load(0);
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) rst = 1'b0;
    ready_timing("por");
    for (int i = 1; i < 8; i++) begin
      @(frame_start);
      load(i);
    end
    @(frame_start);
    chk("queues_drained", q0.size() + q8.size() + q1.size(), 0);

    // async reset in the middle of the left slot, before its capture completes
    for (int k = 0; k < 2000 && mcnt != 6'd10; k++) @(posedge clk);
    chk("reached_slot10", mcnt, 10);
    #2 rst = 1'b1;
    #1 check_reset("mid");
    load(0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ready_timing("mid");
    @(frame_start);
    chk("queues_drained_after_reset", q0.size() + q8.size() + q1.size(), 0);
    chk("strobe_seen_after_reset", last0 >= 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
